// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clocks from start-bit edge to mid-bit.
  function automatic int unsigned uart_half(input int unsigned clk_freq,
                                            input int unsigned baud);
    return uart_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Read-side handshake between the UART receiver and its consumer.
interface uart_rx_byte_if;
  logic [7:0] rdata;
  logic       rdvalid;
  logic       rdack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (output rdata, rdvalid, frame_err, overrun, busy, input rdack);
  modport slave  (input rdata, rdvalid, frame_err, overrun, busy, output rdack);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops; both come out of reset at RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry output register and valid/ack read side.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           RX,
  uart_rx_byte_if.master rd
);
  localparam int unsigned DIV       = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF      = uart_half(CLK_FREQ, BAUD);
  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  logic        rst_n_s;
  logic        rx_s;
  uart_state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [7:0]  sr, sr_nxt;
  logic        byte_done, stop_bad;
  logic [7:0]  rdata_q;
  logic        rdvalid_q, frame_err_q, overrun_q;

  // Reset asserts asynchronously but releases on a clock edge.
  uart_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (1'b1),
    .q     (rst_n_s)
  );

  // Line idles high, so the synchronizer powers up at 1 to avoid a false start.
  uart_sync2 #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n_s),
    .d     (RX),
    .q     (rx_s)
  );

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      sr      <= sr_nxt;
    end
  end

  // Next-state: align to mid-start, then sample every DIV clocks.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sr_nxt    = sr;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          if (!rx_s) begin
            state_nxt = S_DATA;
            cnt_nxt   = '0;
            bit_nxt   = '0;
          end else begin
            // Start bit gone by mid-bit: a glitch, not a frame.
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == DIV_LAST) begin
          sr_nxt  = {rx_s, sr[7:1]};
          cnt_nxt = '0;
          bit_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == DIV_LAST) begin
          // Leave at mid-stop so a following start edge is not missed.
          state_nxt = S_IDLE;
          if (rx_s) byte_done = 1'b1;
          else      stop_bad  = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output register: load, overrun and acknowledge handling.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rdata_q     <= '0;
      rdvalid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      if (byte_done) begin
        if (!rdvalid_q || rd.rdack) begin
          // Ack in the completion cycle frees the slot for the new byte.
          rdata_q   <= sr;
          rdvalid_q <= 1'b1;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rd.rdack && rdvalid_q) begin
        rdvalid_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rd.rdata     = rdata_q;
  assign rd.rdvalid   = rdvalid_q;
  assign rd.frame_err = frame_err_q;
  assign rd.overrun   = overrun_q;
  assign rd.busy      = (state != S_IDLE);

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver, 8N1, LSB first; the counterpart of the board's uart_tx serial transmitter. Runs in the 50 MHz fabric domain. Recovers bytes from the asynchronous RX pin and holds each byte in a one-entry output register. A consumer reads the byte with a valid/ack handshake. The block reports framing errors and overrun.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, serial bit rate
DIV, CLK_FREQ/BAUD (truncated; 434 at default), clocks per bit, derived
HALF, DIV/2 (217 at default), clocks from start-bit edge to mid-bit, derived

Ports:
clk  in  1  system clock, 50 MHz domain
reset_n  in  1  asynchronous, active-low reset
RX  in  1  serial line, asynchronous to clk, idles high
rdack  in  1  consumer acknowledge; one-cycle pulse clears rdvalid
rdata  out  8  received byte, stable while rdvalid=1
rdvalid  out  1  level; high from byte load until acknowledged
frame_err  out  1  one-cycle pulse when the stop bit samples low
overrun  out  1  sticky; set when a byte completes while rdvalid=1 and no rdack in that cycle
busy  out  1  high whenever the FSM is not in S_IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block): rdata=0x00, rdvalid=0, frame_err=0, overrun=0, busy=0, FSM=S_IDLE. Both synchronizer FFs reset to 1.
- RX passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s only.
- Counter cnt: 16 bits; bit index: 3 bits.
- S_IDLE: when rx_s=0, go to S_START with cnt=0.
- S_START: cnt increments. At cnt=HALF-1, sample rx_s:
  - rx_s=0: go to S_DATA, cnt=0, bit=0.
  - rx_s=1: treat as a glitch and return to S_IDLE. Nothing else changes.
- S_DATA: at cnt=DIV-1, shift rx_s into the shift register MSB side (LSB-first reception), set cnt=0, increment bit. After bit 7 is sampled, go to S_STOP.
- S_STOP: at cnt=DIV-1, sample rx_s and return to S_IDLE in the same cycle. Returning at mid-stop-bit allows back-to-back frames.
  - rx_s=1: deliver the byte (see below).
  - rx_s=0: frame_err=1 for exactly one cycle. The byte is discarded; rdata, rdvalid and overrun are unchanged.
- Byte delivery:
  - rdvalid=0: load rdata, set rdvalid=1 on the next edge.
  - rdvalid=1 and rdack=1 in the same cycle: load the new byte, rdvalid stays 1, no overrun.
  - rdvalid=1 and rdack=0: discard the new byte, keep the old rdata, set overrun=1.
- rdack with rdvalid=1: clears rdvalid and overrun next cycle. rdack with rdvalid=0: ignored.
- Latency: from the RX falling edge to rdvalid high = 2 (sync) + HALF + 9*DIV + 1 clocks, which is 4126 at default.
- Line held low (break): the stop bit gives frame_err. The FSM then re-enters S_START at once because rx_s=0, and each further frame also gives frame_err. No lockup.
- Reset mid-frame: the partial byte is lost and the next frame is received normally.

Decomposition:
- Package uart_pkg: state encoding (S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3) and the DIV/HALF computation function. Shared with uart_tx.
- One sub-module, uart_sync2: 2-FF synchronizer with reset value parameter RST_VAL=1. Reused for other async inputs.
- The FSM, counters and output register stay in uart_rx_byte.

Test Plan:
- Send 0xA5 at 115200, stop=1 -> rdvalid rises 4126 clk after the falling edge; rdata=0xA5; frame_err and overrun stay 0; busy=0 afterwards.
- Low glitch of 100 ns (5 clk) on idle line -> FSM returns to S_IDLE at mid-start; rdvalid, frame_err and busy all 0 after the abort.
- Send 0x3C with stop bit forced low -> one-cycle frame_err pulse; rdvalid=0; rdata unchanged (0x00 after reset).
- Back-to-back 0x00 then 0xFF, one stop bit each, rdack never asserted -> rdata=0x00, rdvalid=1, overrun=1. Then pulse rdack -> rdvalid=0, overrun=0.
- Bytes 0x11 then 0x22 with rdack pulsed in the exact cycle 0x22 completes -> rdata=0x22, rdvalid=1, overrun=0.
- Assert reset_n=0 during bit 4 of 0x5A, release, then send 0xC3 -> only 0xC3 delivered. Repeat 0xC3 at baud +2% and -2% -> correct in both cases.
